anc_tap_mem: RTL and testbench

- Parametrised multi-channel tap-delay memory for the ANC FIR/LMS datapath.
- Each channel holds the last NUM_TAPS input samples in a circular buffer. RamShiftEN writes a new SPI sample into one channel.
- A FilterEN request streams that channel's taps, newest first, one per cycle, with valid/last framing.
- Sits between the SPI ADC front end and the filter MAC.

---
 rtl/anc_mem_pkg.sv | 27 ++
 rtl/anc_tap_ram.sv | 50 +++++
 rtl/anc_tap_mem.sv | 215 +++++++++++++++++++++
 tb/tb_anc_tap_mem.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/anc_mem_pkg.sv
// Shared definitions for the ANC tap-delay memory: FSM encoding, width helper
// and the circular-buffer wrap-decrement used to locate taps.
package anc_mem_pkg;

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // (ptr - 1 - idx) mod numTaps for ptr, idx in [0, numTaps-1], without modulo-2^n wrap
  function automatic int wrapDec(input int ptr, input int idx, input int numTaps);
    int a;
    a = ptr - 1 - idx;
    if (a < 0) a = a + numTaps;
    return a;
  endfunction

endpackage

// File: rtl/anc_tap_ram.sv
// Simple dual-port sample RAM addressed by {channel, tap slot}, registered read.
// With ANC_TAP_MEM_ZERO_EN a clear port zeroes one slot in every channel at once.
module anc_tap_ram
  import anc_mem_pkg::*;
#(
  parameter int DATA_W   = 11,
  parameter int NUM_TAPS = 125,
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 7,
  parameter int CH_W     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_wrEn,
  input  logic [CH_W+ADDR_W-1:0]   i_wrAddr,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic [CH_W+ADDR_W-1:0]   i_rdAddr,
`ifdef ANC_TAP_MEM_ZERO_EN
  input  logic                     i_clrEn,
  input  logic [ADDR_W-1:0]        i_clrAddr,
`endif
  output logic [DATA_W-1:0]        o_rdData
);

  localparam int DEPTH = NUM_CH * NUM_TAPS;
  localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [IDX_W-1:0]  w_rdIdx;

  // Packed {ch, slot} folded onto a dense ch*NUM_TAPS+slot index so odd tap counts waste nothing
  assign w_wrIdx = IDX_W'(int'(i_wrAddr[CH_W+ADDR_W-1:ADDR_W]) * NUM_TAPS + int'(i_wrAddr[ADDR_W-1:0]));
  assign w_rdIdx = IDX_W'(int'(i_rdAddr[CH_W+ADDR_W-1:ADDR_W]) * NUM_TAPS + int'(i_rdAddr[ADDR_W-1:0]));

  always_ff @(posedge i_clk) begin
    if (i_wrEn) r_mem[w_wrIdx] <= i_wrData;
`ifdef ANC_TAP_MEM_ZERO_EN
    if (i_clrEn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_mem[IDX_W'(c * NUM_TAPS + int'(i_clrAddr))] <= '0;
      end
    end
`endif
    r_rdData <= r_mem[w_rdIdx];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/anc_tap_mem.sv
// Multi-channel circular tap-delay memory feeding the ANC FIR/LMS MAC.
// Define ANC_TAP_MEM_ZERO_EN to clear all taps after reset (ZERO state).
module anc_tap_mem
  import anc_mem_pkg::*;
#(
  parameter  int DATA_W   = 11,
  parameter  int NUM_TAPS = 125,
  parameter  int NUM_CH   = 2,
  localparam int ADDR_W   = clog2(NUM_TAPS),
  localparam int CH_W     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic              RamShiftEN,
  input  logic [CH_W-1:0]   ShiftCh,
  input  logic [DATA_W-1:0] SPIData,
  input  logic              FilterEN,
  input  logic [CH_W-1:0]   ReadCh,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              DataLast,
  output logic [ADDR_W-1:0] TapIdx,
  output logic              Busy,
  output logic              Overrun
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wrPtr [NUM_CH];
  logic              r_pendValid;
  logic [CH_W-1:0]   r_pendCh;
  logic [DATA_W-1:0] r_pendData;
  logic              r_overrun;
  logic              r_reqValid;
  logic [CH_W-1:0]   r_reqCh;
  logic              r_busy;
  logic [CH_W-1:0]   r_rdCh;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W-1:0] r_tapCnt;
  logic              r_s1Valid;
  logic              r_s1Last;
  logic [ADDR_W-1:0] r_s1Idx;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_dataValid;
  logic              r_dataLast;
  logic [ADDR_W-1:0] r_tapIdx;

  logic              w_idle;
  logic              w_wrEn;
  logic [CH_W-1:0]   w_wrCh;
  logic [DATA_W-1:0] w_wrData;
  logic [ADDR_W-1:0] w_wrAddr;
  logic              w_req;
  logic [CH_W-1:0]   w_reqCh;
  logic              w_accept;
  logic              w_lastTap;
  logic [ADDR_W-1:0] w_tapAddr;
  logic [DATA_W-1:0] w_ramData;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_wrEn    = w_idle && (r_pendValid || RamShiftEN);
  assign w_wrCh    = r_pendValid ? r_pendCh : ShiftCh;
  assign w_wrData  = r_pendValid ? r_pendData : SPIData;
  assign w_wrAddr  = r_wrPtr[w_wrCh];
  assign w_req     = r_reqValid || (FilterEN && !Busy);
  assign w_reqCh   = r_reqValid ? r_reqCh : ReadCh;
  // Writes win over readout so a same-cycle sample shows up as tap 0
  assign w_accept  = w_idle && w_req && !r_pendValid && !RamShiftEN;
  assign w_lastTap = (r_tapCnt == ADDR_W'(NUM_TAPS - 1));
  assign w_tapAddr = ADDR_W'(wrapDec(int'(r_rdPtr), int'(r_tapCnt), NUM_TAPS));

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      for (int c = 0; c < NUM_CH; c++) r_wrPtr[c] <= '0;
    end else if (w_wrEn) begin
      r_wrPtr[w_wrCh] <= (w_wrAddr == ADDR_W'(NUM_TAPS - 1)) ? '0 : w_wrAddr + ADDR_W'(1);
    end
  end

  // Outside IDLE, one write can wait; a second one is lost and flagged until reset
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_pendValid <= 1'b0;
      r_pendCh    <= '0;
      r_pendData  <= '0;
      r_overrun   <= 1'b0;
    end else if (w_idle) begin
      if (r_pendValid) begin
        if (RamShiftEN) begin
          r_pendCh   <= ShiftCh;
          r_pendData <= SPIData;
        end else begin
          r_pendValid <= 1'b0;
        end
      end
    end else if (RamShiftEN) begin
      if (!r_pendValid) begin
        r_pendValid <= 1'b1;
        r_pendCh    <= ShiftCh;
        r_pendData  <= SPIData;
      end else begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_reqValid <= 1'b0;
      r_reqCh    <= '0;
    end else if (w_accept) begin
      r_reqValid <= 1'b0;
    end else if (w_req && !r_reqValid) begin
      r_reqValid <= 1'b1;
      r_reqCh    <= ReadCh;
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
`ifdef ANC_TAP_MEM_ZERO_EN
      r_state <= ST_ZERO;
`else
      r_state <= ST_IDLE;
`endif
      r_rdCh   <= '0;
      r_rdPtr  <= '0;
      r_tapCnt <= '0;
    end else begin
      case (r_state)
`ifdef ANC_TAP_MEM_ZERO_EN
        ST_ZERO: begin
          if (w_lastTap) begin
            r_state  <= ST_IDLE;
            r_tapCnt <= '0;
          end else begin
            r_tapCnt <= r_tapCnt + ADDR_W'(1);
          end
        end
`endif
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_READ;
            r_rdCh   <= w_reqCh;
            r_rdPtr  <= r_wrPtr[w_reqCh];
            r_tapCnt <= '0;
          end
        end
        ST_READ: begin
          if (w_lastTap) r_state <= ST_DRAIN;
          else           r_tapCnt <= r_tapCnt + ADDR_W'(1);
        end
        ST_DRAIN: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Busy spans acceptance until the final tap leaves the output register
  always_ff @(posedge Clk_100M) begin
    if (Reset)           r_busy <= 1'b0;
    else if (w_accept)   r_busy <= 1'b1;
    else if (r_dataLast) r_busy <= 1'b0;
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_s1Valid   <= 1'b0;
      r_s1Last    <= 1'b0;
      r_s1Idx     <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_dataLast  <= 1'b0;
      r_tapIdx    <= '0;
    end else begin
      r_s1Valid   <= (r_state == ST_READ);
      r_s1Last    <= (r_state == ST_READ) && w_lastTap;
      r_s1Idx     <= r_tapCnt;
      r_dataValid <= r_s1Valid;
      r_dataLast  <= r_s1Last;
      r_tapIdx    <= r_s1Valid ? r_s1Idx : '0;
      if (r_s1Valid) r_dataOut <= w_ramData;
    end
  end

  anc_tap_ram #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS),
    .NUM_CH   (NUM_CH),
    .ADDR_W   (ADDR_W),
    .CH_W     (CH_W)
  ) u_ram (
    .i_clk     (Clk_100M),
    .i_wrEn    (w_wrEn),
    .i_wrAddr  ({w_wrCh, w_wrAddr}),
    .i_wrData  (w_wrData),
    .i_rdAddr  ({r_rdCh, w_tapAddr}),
`ifdef ANC_TAP_MEM_ZERO_EN
    .i_clrEn   (r_state == ST_ZERO),
    .i_clrAddr (r_tapCnt),
`endif
    .o_rdData  (w_ramData)
  );

`ifdef ANC_TAP_MEM_ZERO_EN
  assign Busy = r_busy || (r_state == ST_ZERO);
`else
  assign Busy = r_busy;
`endif
  assign DataOut   = r_dataOut;
  assign DataValid = r_dataValid;
  assign DataLast  = r_dataLast;
  assign TapIdx    = r_tapIdx;
  assign Overrun   = r_overrun;

endmodule

// File: tb/tb_anc_tap_mem.sv
// Directed bench for anc_tap_mem with 8 taps x 2 channels: ordering, isolation,
// deferred/overrun writes, write/read collision and mid-readout reset.
module tb_anc_tap_mem;

  localparam int DATA_W   = 11;
  localparam int NUM_TAPS = 8;
  localparam int NUM_CH   = 2;
  localparam int ADDR_W   = 3;
  localparam int CH_W     = 1;

  logic              Clk_100M = 1'b0;
  logic              Reset;
  logic              RamShiftEN;
  logic [CH_W-1:0]   ShiftCh;
  logic [DATA_W-1:0] SPIData;
  logic              FilterEN;
  logic [CH_W-1:0]   ReadCh;
  logic [DATA_W-1:0] DataOut;
  logic              DataValid;
  logic              DataLast;
  logic [ADDR_W-1:0] TapIdx;
  logic              Busy;
  logic              Overrun;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] expv [NUM_TAPS];

  always #5 Clk_100M = ~Clk_100M;

  anc_tap_mem #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS),
    .NUM_CH   (NUM_CH)
  ) dut (
    .Clk_100M   (Clk_100M),
    .Reset      (Reset),
    .RamShiftEN (RamShiftEN),
    .ShiftCh    (ShiftCh),
    .SPIData    (SPIData),
    .FilterEN   (FilterEN),
    .ReadCh     (ReadCh),
    .DataOut    (DataOut),
    .DataValid  (DataValid),
    .DataLast   (DataLast),
    .TapIdx     (TapIdx),
    .Busy       (Busy),
    .Overrun    (Overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk_100M);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [CH_W-1:0] wch, input logic [DATA_W-1:0] d,
                               input logic fen, input logic [CH_W-1:0] rch);
    RamShiftEN = wr;
    ShiftCh    = wch;
    SPIData    = d;
    FilterEN   = fen;
    ReadCh     = rch;
  endtask

  task automatic doWrite(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
    applyStimulus(1'b1, ch, d, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Request in an idle, write-free cycle: the edge that samples it is the acceptance edge
  task automatic startRead(input logic [CH_W-1:0] ch);
    applyStimulus(1'b0, '0, '0, 1'b1, ch);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Entered just after the acceptance edge; optional writes and a busy FilterEN are injected mid-stream
  task automatic checkStream(input int nCheck, input int wrCount, input logic [CH_W-1:0] wch,
                             input logic [DATA_W-1:0] wd0, input logic [DATA_W-1:0] wd1,
                             input logic busyReq);
    checkOutput("busy_at_accept", Busy, 1);
    tick();
    checkOutput("valid_latency", DataValid, 0);
    for (int i = 0; i < NUM_TAPS; i++) begin
      applyStimulus((i == 2 && wrCount >= 1) || (i == 3 && wrCount >= 2), wch,
                    (i == 3) ? wd1 : wd0, busyReq && (i == 4), '0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      checkOutput($sformatf("valid_t%0d", i), DataValid, 1);
      checkOutput($sformatf("tapidx_t%0d", i), TapIdx, i);
      checkOutput($sformatf("last_t%0d", i), DataLast, (i == NUM_TAPS - 1));
      checkOutput($sformatf("busy_t%0d", i), Busy, 1);
      if (i < nCheck) checkOutput($sformatf("data_t%0d", i), DataOut, expv[i]);
      if (wrCount == 2 && i == 3) checkOutput("overrun_set", Overrun, 1);
    end
    tick();
    checkOutput("valid_end", DataValid, 0);
    checkOutput("busy_end", Busy, 0);
    checkOutput("last_end", DataLast, 0);
    checkOutput("tapidx_end", TapIdx, 0);
    if (nCheck == NUM_TAPS) checkOutput("data_hold", DataOut, expv[NUM_TAPS-1]);
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_dataout", DataOut, 0);
    checkOutput("rst_valid", DataValid, 0);
    checkOutput("rst_last", DataLast, 0);
    checkOutput("rst_tapidx", TapIdx, 0);
    checkOutput("rst_overrun", Overrun, 0);
`ifndef ANC_TAP_MEM_ZERO_EN
    checkOutput("rst_busy", Busy, 0);
`endif
    Reset = 1'b0;
`ifdef ANC_TAP_MEM_ZERO_EN
    checkOutput("zero_busy", Busy, 1);
    repeat (NUM_TAPS) tick();
    checkOutput("zero_done", Busy, 0);
    expv = '{0, 0, 0, 0, 0, 0, 0, 0};
    startRead(1);
    checkStream(8, 0, '0, '0, '0, 1'b0);
`endif

    $display("[TB] wrap order");
    for (int v = 1; v <= 10; v++) doWrite(0, DATA_W'(v));
    expv = '{10, 9, 8, 7, 6, 5, 4, 3};
    startRead(0);
    checkStream(8, 0, '0, '0, '0, 1'b0);

    $display("[TB] channel isolation");
    for (int v = 1; v <= 4; v++) doWrite(0, DATA_W'(v));
    doWrite(1, 100);
    for (int v = 5; v <= 8; v++) doWrite(0, DATA_W'(v));
    expv = '{100, 0, 0, 0, 0, 0, 0, 0};
    startRead(1);
    checkStream(1, 0, '0, '0, '0, 1'b0);
    expv = '{8, 7, 6, 5, 4, 3, 2, 1};
    startRead(0);
    checkStream(8, 0, '0, '0, '0, 1'b0);

    $display("[TB] deferred write");
    startRead(0);
    checkStream(8, 1, 0, 300, 0, 1'b0);
    checkOutput("deferred_no_overrun", Overrun, 0);
    expv = '{300, 8, 7, 6, 5, 4, 3, 2};
    startRead(0);
    checkStream(8, 0, '0, '0, '0, 1'b0);

    $display("[TB] overrun");
    expv = '{100, 0, 0, 0, 0, 0, 0, 0};
    startRead(1);
    checkStream(1, 2, 1, 200, 201, 1'b0);
    checkOutput("overrun_sticky", Overrun, 1);
    expv = '{200, 100, 0, 0, 0, 0, 0, 0};
    startRead(1);
    checkStream(2, 0, '0, '0, '0, 1'b0);
    checkOutput("overrun_still", Overrun, 1);

    $display("[TB] collision");
    applyStimulus(1'b1, 0, 55, 1'b1, 0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("collision_deferred", Busy, 0);
    tick();
    expv = '{55, 300, 8, 7, 6, 5, 4, 3};
    checkStream(8, 0, '0, '0, '0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      tick();
      checkOutput($sformatf("no_second_read_%0d", j), DataValid, 0);
    end
    checkOutput("no_second_busy", Busy, 0);

    $display("[TB] reset mid-readout");
    startRead(0);
    repeat (4) tick();
    checkOutput("pre_reset_valid", DataValid, 1);
    Reset = 1'b1;
    tick();
    checkOutput("mid_rst_valid", DataValid, 0);
    checkOutput("mid_rst_dataout", DataOut, 0);
    checkOutput("mid_rst_last", DataLast, 0);
    checkOutput("mid_rst_overrun", Overrun, 0);
`ifndef ANC_TAP_MEM_ZERO_EN
    checkOutput("mid_rst_busy", Busy, 0);
`endif
    Reset = 1'b0;
    tick();
    checkOutput("post_rst_valid", DataValid, 0);
`ifdef ANC_TAP_MEM_ZERO_EN
    repeat (NUM_TAPS) tick();
    checkOutput("post_rst_zero_done", Busy, 0);
    doWrite(0, 77);
    doWrite(0, 78);
    expv = '{78, 77, 0, 0, 0, 0, 0, 0};
    startRead(0);
    checkStream(8, 0, '0, '0, '0, 1'b0);
`else
    doWrite(0, 77);
    doWrite(0, 78);
    expv = '{78, 77, 0, 0, 0, 0, 0, 0};
    startRead(0);
    checkStream(2, 0, '0, '0, '0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
